// File: rtl/dg_pkg.sv
// Shared definitions for the data-generator run controller and the generator wrappers.
package dg_pkg;

   localparam int DG_NPORT  = 16;
   localparam int DG_ADDR_W = 10;
   localparam int DG_GAP_W  = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_GRANT = 3'd1,
      ST_GAP   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } dg_state_t;

endpackage

// File: rtl/dg_rr_pick.sv
// Combinational round-robin picker: first eligible port at or after ptr, wrapping.
module dg_rr_pick #(
   parameter int NPORT = 16,
   parameter int PTR_W = 4
) (
   input  logic [NPORT-1:0] elig,
   input  logic [PTR_W-1:0] ptr,
   output logic [PTR_W-1:0] idx,
   output logic             any
);

   logic [PTR_W-1:0] cand;

   always_comb begin
      any  = 1'b0;
      idx  = '0;
      cand = '0;
      for (int i = 0; i < NPORT; i++) begin
         cand = PTR_W'((int'(ptr) + i) % NPORT);
         if (!any && elig[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/dg_run_ctl.sv
// Run controller: releases per-port packet budgets in round-robin order and tracks completed packets.
//
// state | meaning
// IDLE  | waiting for i_start; eop here is an error
// GRANT | hand one packet budget to the next eligible port
// GAP   | count down the inter-grant gap
// DRAIN | all budgets granted, wait for every enabled port's eops
// DONE  | one-cycle completion pulse
module dg_run_ctl
   import dg_pkg::*;
#(
   parameter int NPORT  = DG_NPORT,
   parameter int ADDR_W = DG_ADDR_W,
   parameter int GAP_W  = DG_GAP_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_start,
   input  logic                    i_abort,
   input  logic [ADDR_W-1:0]       i_pkt_num,
   input  logic [GAP_W-1:0]        i_gap,
   input  logic [NPORT-1:0]        i_port_en,
   input  logic [NPORT-1:0]        i_eop,
   output logic [NPORT*ADDR_W-1:0] o_fetch_n,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_err
);

   localparam int PTR_W = (NPORT > 1) ? $clog2(NPORT) : 1;

   dg_state_t         state, state_nxt;
   logic [ADDR_W-1:0] pkt_num_q;
   logic [GAP_W-1:0]  gap_q, gap_cnt;
   logic [NPORT-1:0]  en_q, elig, eop_inc;
   logic [PTR_W-1:0]  ptr, pick_idx;
   logic              pick_any;
   logic [ADDR_W-1:0] fetch_n [NPORT];
   logic [ADDR_W-1:0] eop_cnt [NPORT];
   logic              start_acc, grant_fire, gap_load, gap_dec, all_done, eop_err;

   always_comb begin
      elig     = '0;
      all_done = 1'b1;
      for (int p = 0; p < NPORT; p++) begin
         elig[p] = en_q[p] && (fetch_n[p] < pkt_num_q);
         if (en_q[p] && (eop_cnt[p] != pkt_num_q))
            all_done = 1'b0;
      end
   end

   dg_rr_pick #(
      .NPORT (NPORT),
      .PTR_W (PTR_W)
   ) u_pick (
      .elig (elig),
      .ptr  (ptr),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   // An eop is only counted against an outstanding grant on an enabled port during a run.
   always_comb begin
      eop_inc = '0;
      eop_err = 1'b0;
      for (int p = 0; p < NPORT; p++) begin
         if (i_eop[p]) begin
            if ((state == ST_IDLE) || !en_q[p] || (eop_cnt[p] == fetch_n[p]))
               eop_err = 1'b1;
            else if (eop_cnt[p] != '1)
               eop_inc[p] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      start_acc  = 1'b0;
      grant_fire = 1'b0;
      gap_load   = 1'b0;
      gap_dec    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_start) begin
               start_acc = 1'b1;
               state_nxt = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (i_abort) begin
               state_nxt = ST_IDLE;
            end else if (pick_any) begin
               grant_fire = 1'b1;
               if (gap_q != '0) begin
                  gap_load  = 1'b1;
                  state_nxt = ST_GAP;
               end
            end else begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_GAP: begin
            if (i_abort)
               state_nxt = ST_IDLE;
            else if (gap_cnt <= GAP_W'(1))
               state_nxt = ST_GRANT;
            else
               gap_dec = 1'b1;
         end
         ST_DRAIN: begin
            if (i_abort)
               state_nxt = ST_IDLE;
            else if (all_done)
               state_nxt = ST_DONE;
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_num_q <= '0;
         gap_q     <= '0;
         en_q      <= '0;
         ptr       <= '0;
         gap_cnt   <= '0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_err     <= 1'b0;
         for (int p = 0; p < NPORT; p++) begin
            fetch_n[p] <= '0;
            eop_cnt[p] <= '0;
         end
      end else begin
         o_busy <= (state_nxt != ST_IDLE);
         o_done <= (state_nxt == ST_DONE);

         if (eop_err)
            o_err <= 1'b1;
         else if (start_acc)
            o_err <= 1'b0;

         if (start_acc) begin
            pkt_num_q <= i_pkt_num;
            gap_q     <= i_gap;
            en_q      <= i_port_en;
            ptr       <= '0;
            for (int p = 0; p < NPORT; p++) begin
               fetch_n[p] <= '0;
               eop_cnt[p] <= '0;
            end
         end else begin
            for (int p = 0; p < NPORT; p++) begin
               if (eop_inc[p])
                  eop_cnt[p] <= eop_cnt[p] + ADDR_W'(1);
            end
            if (grant_fire) begin
               fetch_n[pick_idx] <= fetch_n[pick_idx] + ADDR_W'(1);
               ptr <= (int'(pick_idx) == NPORT - 1) ? '0 : pick_idx + PTR_W'(1);
            end
         end

         if (gap_load)
            gap_cnt <= gap_q;
         else if (gap_dec)
            gap_cnt <= gap_cnt - GAP_W'(1);
      end
   end

   for (genvar p = 0; p < NPORT; p++) begin : g_fetch
      assign o_fetch_n[p*ADDR_W +: ADDR_W] = fetch_n[p];
   end

endmodule

// File: tb/tb_dg_run_ctl.sv
// Self-checking bench for dg_run_ctl with four ports and an immediate-eop generator model.
module tb_dg_run_ctl;

   localparam int NPORT  = 4;
   localparam int ADDR_W = 10;
   localparam int GAP_W  = 8;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    i_start, i_abort;
   logic [ADDR_W-1:0]       i_pkt_num;
   logic [GAP_W-1:0]        i_gap;
   logic [NPORT-1:0]        i_port_en, i_eop;
   logic [NPORT*ADDR_W-1:0] o_fetch_n;
   logic                    o_busy, o_done, o_err;

   dg_run_ctl #(.NPORT(NPORT), .ADDR_W(ADDR_W), .GAP_W(GAP_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_start   (i_start),
      .i_abort   (i_abort),
      .i_pkt_num (i_pkt_num),
      .i_gap     (i_gap),
      .i_port_en (i_port_en),
      .i_eop     (i_eop),
      .o_fetch_n (o_fetch_n),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_err     (o_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                      pkt;
      int                      gap;
      logic [NPORT-1:0]        en;
      logic [NPORT*ADDR_W-1:0] exp_f;
      int                      busy;
      int                      done_off;
   } vec_t;

   typedef struct {
      int port;
      int cyc;
   } grant_t;

   vec_t              vecs[6];
   grant_t            exp_q[$];
   logic [ADDR_W-1:0] prev_f[NPORT];
   int                gen_emit[NPORT];
   bit                gen_on, sb_on;
   int                cyc, done_cnt, done_cyc;
   int                checks, failures;

   function automatic logic [ADDR_W-1:0] get_f(int p);
      return o_fetch_n[p*ADDR_W +: ADDR_W];
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One clock: sample after the edge, score grants, then drive the generator's eops.
   task automatic tick();
      grant_t           e;
      logic [NPORT-1:0] eb;
      @(posedge clk);
      #1;
      cyc++;
      for (int p = 0; p < NPORT; p++) begin
         if (sb_on && (get_f(p) == prev_f[p] + ADDR_W'(1))) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_grant actual=port%0d@%0d required=none", p, cyc);
            end else begin
               e = exp_q.pop_front();
               check("grant_port", 64'(p), 64'(e.port));
               check("grant_cycle", 64'(cyc), 64'(e.cyc));
            end
         end
         prev_f[p] = get_f(p);
      end
      if (o_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      eb = '0;
      for (int p = 0; p < NPORT; p++) begin
         if (gen_on && (int'(get_f(p)) > gen_emit[p])) begin
            eb[p] = 1'b1;
            gen_emit[p]++;
         end
      end
      i_eop = eb;
   endtask

   task automatic start_run(int pkt, int gap, logic [NPORT-1:0] en, output int k);
      for (int p = 0; p < NPORT; p++) gen_emit[p] = 0;
      i_pkt_num = ADDR_W'(pkt);
      i_gap     = GAP_W'(gap);
      i_port_en = en;
      i_start   = 1'b1;
      tick();
      i_start   = 1'b0;
      k         = cyc;
      done_cnt  = 0;
      check("start_fetch_clear", 64'(o_fetch_n), 64'(0));
      check("start_err_clear", 64'(o_err), 64'(0));
      check("start_busy", 64'(o_busy), 64'(1));
   endtask

   task automatic push_grants(int pkt, int gap, logic [NPORT-1:0] en, int k, int max_n);
      int cnt[NPORT];
      int ptr, j, found;
      ptr = 0;
      j   = 0;
      for (int p = 0; p < NPORT; p++) cnt[p] = 0;
      for (int n = 0; n < max_n; n++) begin
         found = -1;
         for (int i = 0; i < NPORT; i++) begin
            int c;
            c = (ptr + i) % NPORT;
            if (found < 0 && en[c] && cnt[c] < pkt) found = c;
         end
         if (found < 0) break;
         exp_q.push_back('{found, k + 1 + j * (gap + 1)});
         cnt[found]++;
         ptr = (found + 1) % NPORT;
         j++;
      end
   endtask

   task automatic run_vec(int id, vec_t v);
      int k, busy_cnt, guard;
      gen_on = 1'b1;
      sb_on  = 1'b1;
      start_run(v.pkt, v.gap, v.en, k);
      push_grants(v.pkt, v.gap, v.en, k, 64);
      busy_cnt = 1;
      guard    = 0;
      while (o_busy && guard < 300) begin
         tick();
         if (o_busy) busy_cnt++;
         guard++;
      end
      check($sformatf("v%0d_timeout", id), 64'(guard < 300), 64'(1));
      check($sformatf("v%0d_busy_cycles", id), 64'(busy_cnt), 64'(v.busy));
      check($sformatf("v%0d_done_pulses", id), 64'(done_cnt), 64'(1));
      check($sformatf("v%0d_done_offset", id), 64'(done_cyc - k), 64'(v.done_off));
      check($sformatf("v%0d_fetch_final", id), 64'(o_fetch_n), 64'(v.exp_f));
      check($sformatf("v%0d_grants_left", id), 64'(exp_q.size()), 64'(0));
      check($sformatf("v%0d_err", id), 64'(o_err), 64'(0));
      exp_q.delete();
   endtask

   initial begin
      int k;
      checks   = 0;
      failures = 0;
      cyc      = 0;
      gen_on   = 1'b0;
      sb_on    = 1'b0;
      rst      = 1'b1;
      i_start  = 1'b0;
      i_abort  = 1'b0;
      i_pkt_num = '0;
      i_gap    = '0;
      i_port_en = '0;
      i_eop    = '0;
      for (int p = 0; p < NPORT; p++) begin
         prev_f[p]   = '0;
         gen_emit[p] = 0;
      end

      vecs[0] = '{2, 0, 4'hF,    {10'd2, 10'd2, 10'd2, 10'd2}, 11, 10};
      vecs[1] = '{1, 3, 4'b0011, {10'd0, 10'd0, 10'd1, 10'd1}, 11, 10};
      vecs[2] = '{3, 0, 4'b0101, {10'd0, 10'd3, 10'd0, 10'd3}, 9,  8};
      vecs[3] = '{0, 0, 4'hF,    {10'd0, 10'd0, 10'd0, 10'd0}, 3,  2};
      vecs[4] = '{2, 1, 4'b1000, {10'd2, 10'd0, 10'd0, 10'd0}, 7,  6};
      vecs[5] = '{5, 2, 4'b0000, {10'd0, 10'd0, 10'd0, 10'd0}, 3,  2};

      repeat (3) @(posedge clk);
      #1;
      check("rst_fetch", 64'(o_fetch_n), 64'(0));
      check("rst_busy", 64'(o_busy), 64'(0));
      check("rst_done", 64'(o_done), 64'(0));
      check("rst_err", 64'(o_err), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

      // eop on p1 before p1 has any grant
      gen_on = 1'b0;
      sb_on  = 1'b1;
      start_run(2, 5, 4'hF, k);
      push_grants(2, 5, 4'hF, k, 1);
      tick();
      i_eop = i_eop | 4'b0010;
      tick();
      check("err_set", 64'(o_err), 64'(1));
      repeat (3) tick();
      check("err_sticky", 64'(o_err), 64'(1));
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      check("err_abort_idle", 64'(o_busy), 64'(0));
      check("err_after_abort", 64'(o_err), 64'(1));
      repeat (8) tick();
      check("err_no_more_grants", 64'(o_fetch_n), 64'({10'd0, 10'd0, 10'd0, 10'd1}));
      check("err_grants_left", 64'(exp_q.size()), 64'(0));
      exp_q.delete();

      // abort in the middle of a gap
      gen_on = 1'b1;
      start_run(3, 4, 4'hF, k);
      push_grants(3, 4, 4'hF, k, 1);
      repeat (3) tick();
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      check("abort_idle", 64'(o_busy), 64'(0));
      check("abort_fetch_frozen", 64'(o_fetch_n), 64'({10'd0, 10'd0, 10'd0, 10'd1}));
      repeat (10) tick();
      check("abort_fetch_hold", 64'(o_fetch_n), 64'({10'd0, 10'd0, 10'd0, 10'd1}));
      check("abort_no_done", 64'(done_cnt), 64'(0));
      check("abort_err", 64'(o_err), 64'(0));
      check("abort_grants_left", 64'(exp_q.size()), 64'(0));
      exp_q.delete();

      // eop while idle
      i_eop = 4'b0100;
      tick();
      check("idle_eop_err", 64'(o_err), 64'(1));
      run_vec(6, vecs[0]);

      // asynchronous reset in the middle of a run
      gen_on = 1'b0;
      sb_on  = 1'b0;
      start_run(3, 0, 4'hF, k);
      repeat (3) tick();
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_fetch", 64'(o_fetch_n), 64'(0));
      check("async_rst_busy", 64'(o_busy), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("after_rst_idle", 64'(o_busy), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
